// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command engine: power-up clocks, 48-bit command frame, R1 / R3 / R7 capture.
// Define SD_CRC_EN for a serial CRC7. Without it, a constant CRC that is valid for CMD0 and CMD8 is sent.
module sd_spi_cmd_engine #(
    parameter int LOWFREQ_POWER2  = 7,
    parameter int HIGHFREQ_POWER2 = 1,
    parameter int INIT_CLOCKS     = 80,
    parameter int RESP_TIMEOUT    = 16,
    parameter int TRAIL_CLOCKS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  command,
    input  logic [31:0] arg,
    input  logic        resp_long,
    input  logic        fast_clk,
    output logic        command_sent,
    output logic [39:0] response,
    output logic        response_ready,
    output logic        timeout,
    input  logic        miso,
    output logic        mosi,
    output logic        sdclk,
    output logic        sd_chip_select
);
    localparam int DIV_W     = (LOWFREQ_POWER2 > HIGHFREQ_POWER2) ? LOWFREQ_POWER2 : HIGHFREQ_POWER2;
    localparam int POLL_BITS = RESP_TIMEOUT * 8;
    localparam int POLL_W    = $clog2(POLL_BITS);
    localparam int PHASE_MAX = (INIT_CLOCKS > TRAIL_CLOCKS) ? INIT_CLOCKS : TRAIL_CLOCKS;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [DIV_W-1:0]   SLOW_HALF  = DIV_W'((1 << (LOWFREQ_POWER2 - 1)) - 1);
    localparam logic [DIV_W-1:0]   FAST_HALF  = DIV_W'((1 << (HIGHFREQ_POWER2 - 1)) - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_BITS - 1);
    localparam logic [PHASE_W-1:0] INIT_LAST  = PHASE_W'(INIT_CLOCKS - 1);
    localparam logic [PHASE_W-1:0] TRAIL_LAST = PHASE_W'(TRAIL_CLOCKS);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SEND, ST_POLL, ST_RECV, ST_TRAIL} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   half_m1;
    logic               tick, sck_rise, sck_fall;
    logic               fast_r, long_r;
    logic [46:0]        frame_sr, frame_next;
    logic               mosi_next;
    logic [5:0]         bit_cnt, resp_last;
    logic [POLL_W-1:0]  poll_cnt;
    logic [PHASE_W-1:0] phase_cnt;
    logic [38:0]        resp_sr;
    logic [39:0]        resp_next;
    logic [6:0]         frame_crc;
`ifdef SD_CRC_EN
    logic [6:0]         crc, crc_upd;
`endif

    // Each sdclk half-period lasts half_m1+1 clk cycles. A tick toggles sdclk.
    assign half_m1   = fast_r ? FAST_HALF : SLOW_HALF;
    assign tick      = (div_cnt == half_m1);
    assign sck_rise  = tick && !sdclk;
    assign sck_fall  = tick && sdclk;
    assign resp_next = {resp_sr, miso};
    assign resp_last = long_r ? 6'd39 : 6'd7;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        frame_next = {frame_sr[45:0], 1'b0};
        mosi_next  = frame_sr[46];
`ifdef SD_CRC_EN
        crc_upd   = {crc[5:0], 1'b0} ^ ({7{mosi ^ crc[6]}} & 7'h09);
        frame_crc = 7'h00;
        if (bit_cnt == 6'd39) begin
            mosi_next          = crc_upd[6];
            frame_next[46:41]  = crc_upd[5:0];
        end
`else
        case (command)
            6'd0:    frame_crc = 7'h4A;
            6'd8:    frame_crc = 7'h43;
            default: frame_crc = 7'h7F;
        endcase
`endif
    end

    // NOTE: all state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_INIT;
            div_cnt        <= '0;
            sdclk          <= 1'b0;
            mosi           <= 1'b1;
            sd_chip_select <= 1'b1;
            cmd_ready      <= 1'b0;
            command_sent   <= 1'b0;
            response_ready <= 1'b0;
            timeout        <= 1'b0;
            response       <= '0;
            fast_r         <= 1'b0;
            long_r         <= 1'b0;
            frame_sr       <= '0;
            bit_cnt        <= '0;
            poll_cnt       <= '0;
            phase_cnt      <= '0;
            resp_sr        <= '0;
`ifdef SD_CRC_EN
            crc            <= '0;
`endif
        end else begin
            command_sent   <= 1'b0;
            response_ready <= 1'b0;
            timeout        <= 1'b0;

            if (state == ST_IDLE) begin
                div_cnt <= '0;
                sdclk   <= 1'b0;
            end else if (tick) begin
                div_cnt <= '0;
                sdclk   <= ~sdclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                ST_INIT: if (sck_fall) begin
                    if (phase_cnt == INIT_LAST) begin
                        phase_cnt <= '0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready      <= 1'b0;
                    fast_r         <= fast_clk;
                    long_r         <= resp_long;
                    frame_sr       <= {1'b1, command, arg, frame_crc, 1'b1};
                    mosi           <= 1'b0;
                    sd_chip_select <= 1'b0;
                    bit_cnt        <= '0;
`ifdef SD_CRC_EN
                    crc            <= '0;
`endif
                    state          <= ST_SEND;
                end
                ST_SEND: if (sck_fall) begin
                    if (bit_cnt == 6'd47) begin
                        command_sent <= 1'b1;
                        mosi         <= 1'b1;
                        poll_cnt     <= '0;
                        state        <= ST_POLL;
                    end else begin
                        frame_sr <= frame_next;
                        mosi     <= mosi_next;
                        bit_cnt  <= bit_cnt + 1'b1;
`ifdef SD_CRC_EN
                        if (bit_cnt < 6'd40) crc <= crc_upd;
`endif
                    end
                end
                ST_POLL: if (sck_rise) begin
                    if (!miso) begin
                        resp_sr <= '0;
                        bit_cnt <= 6'd1;
                        state   <= ST_RECV;
                    end else if (poll_cnt == POLL_LAST) begin
                        response       <= '1;
                        response_ready <= 1'b1;
                        timeout        <= 1'b1;
                        phase_cnt      <= '0;
                        state          <= ST_TRAIL;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                ST_RECV: if (sck_rise) begin
                    resp_sr <= resp_next[38:0];
                    if (bit_cnt == resp_last) begin
                        response       <= long_r ? resp_next : {resp_next[7:0], 32'h0};
                        response_ready <= 1'b1;
                        phase_cnt      <= '0;
                        state          <= ST_TRAIL;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_TRAIL: if (sck_fall) begin
                    // The first fall closes the last response bit; the gap clocks follow with CS high.
                    sd_chip_select <= 1'b1;
                    if (phase_cnt == TRAIL_LAST) begin
                        phase_cnt <= '0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Self-checking bench for sd_spi_cmd_engine. A card model answers each frame.
// The expected frames and responses come from a transaction-level reference model.
module tb_sd_spi_cmd_engine;
    localparam int LOWP   = 2;
    localparam int HIGHP  = 1;
    localparam int INITC  = 12;
    localparam int RTO    = 4;
    localparam int TRAILC = 8;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [5:0]  command = '0;
    logic [31:0] arg = '0;
    logic        resp_long = 1'b0, fast_clk = 1'b0, miso = 1'b1;
    logic        cmd_ready, command_sent, response_ready, timeout, mosi, sdclk, sd_chip_select;
    logic [39:0] response;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [47:0] frame;
        int          nbits;
        int          n_sent;
        int          n_rdy;
        int          n_to;
        logic [39:0] resp;
        logic        to;
        int          bad_period;
        int          n_period;
        int          trail;
        bit          done;
    } obs_t;

    always #5 clk = ~clk;

    sd_spi_cmd_engine #(
        .LOWFREQ_POWER2(LOWP), .HIGHFREQ_POWER2(HIGHP), .INIT_CLOCKS(INITC),
        .RESP_TIMEOUT(RTO), .TRAIL_CLOCKS(TRAILC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .command(command), .arg(arg), .resp_long(resp_long), .fast_clk(fast_clk),
        .command_sent(command_sent), .response(response), .response_ready(response_ready),
        .timeout(timeout), .miso(miso), .mosi(mosi), .sdclk(sdclk), .sd_chip_select(sd_chip_select)
    );

    // CRC7 as the remainder of polynomial division by x^7+x^3+1.
    function automatic logic [6:0] ref_crc(input logic [5:0] c, input logic [31:0] a);
`ifdef SD_CRC_EN
        logic [46:0] m;
        m = {2'b01, c, a, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (m[i]) m = m ^ (47'h89 << (i - 7));
        return m[6:0];
`else
        if (c == 6'd0) return 7'h4A;
        if (c == 6'd8) return 7'h43;
        return 7'h7F;
`endif
    endfunction

    function automatic logic [47:0] ref_frame(input logic [5:0] c, input logic [31:0] a);
        return {2'b01, c, a, ref_crc(c, a), 1'b1};
    endfunction

    function automatic logic [39:0] ref_resp(input logic lng, input int ones, input logic [39:0] r);
        if (ones >= RTO * 8) return 40'hFF_FFFF_FFFF;
        return lng ? r : {r[39:32], 32'h0};
    endfunction

    // Bit the card presents for post-frame clock number idx.
    function automatic logic card_bit(input int idx, input int ones, input logic [39:0] r, input logic lng);
        int len;
        len = lng ? 40 : 8;
        if (idx < ones) return 1'b1;
        if (idx < ones + len) return r[39 - (idx - ones)];
        return 1'b1;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic xfer(input logic [5:0] c, input logic [31:0] a, input logic lng, input logic fst,
                        input int ones, input logic [39:0] r, output obs_t o);
        bit   ok;
        logic prev_sck;
        int   last_rise, post, per;
        o = '{default: 0};
        per = 1 << (fst ? HIGHP : LOWP);
        wait_ready(ok);
        if (!ok) return;
        cmd_valid = 1'b1; command = c; arg = a; resp_long = lng; fast_clk = fst; miso = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        prev_sck = sdclk; last_rise = -1; post = 0;
        for (int i = 0; i < 6000; i++) begin
            command = 6'($urandom); arg = $urandom; resp_long = 1'($urandom); fast_clk = 1'($urandom);
            if (sdclk && !prev_sck) begin
                if (!sd_chip_select) begin
                    if (last_rise >= 0) begin
                        o.n_period++;
                        if (i - last_rise != per) o.bad_period++;
                    end
                    last_rise = i;
                    if (o.nbits < 48) begin
                        o.frame = {o.frame[46:0], mosi};
                        o.nbits++;
                    end else begin
                        post++;
                    end
                end else if (o.n_rdy > 0) begin
                    o.trail++;
                end
            end
            if (!sdclk && prev_sck) miso = (o.nbits == 48) ? card_bit(post, ones, r, lng) : 1'b1;
            if (command_sent) o.n_sent++;
            if (response_ready) begin
                o.n_rdy++;
                o.resp = response;
                o.to   = timeout;
            end
            if (timeout) o.n_to++;
            if (cmd_ready) begin
                o.done = 1'b1;
                break;
            end
            prev_sck = sdclk;
            @(negedge clk);
        end
        miso = 1'b1;
    endtask

    task automatic test_reset;
        logic prev_sck;
        int   rises, bad, bad_per, last_rise;
        bit   seen;
        rst = 1'b1; cmd_valid = 1'b1; command = 6'd8; arg = 32'h1AA;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({cmd_ready, command_sent, response, response_ready, timeout, mosi, sdclk, sd_chip_select} !==
            {1'b0, 1'b0, 40'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b sent=%b resp=%h rr=%b to=%b mosi=%b sck=%b cs=%b expected 0 0 0 0 0 1 0 1",
                     cmd_ready, command_sent, response, response_ready, timeout, mosi, sdclk, sd_chip_select);
        end
        rst = 1'b0;
        prev_sck = sdclk; rises = 0; bad = 0; bad_per = 0; last_rise = -1; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                seen = 1'b1;
                cmd_valid = 1'b0;
                break;
            end
            if (!sd_chip_select || !mosi) bad++;
            if (sdclk && !prev_sck) begin
                rises++;
                if (last_rise >= 0 && i - last_rise != (1 << LOWP)) bad_per++;
                last_rise = i;
            end
            prev_sck = sdclk;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!seen || rises !== INITC) begin
            n_fail++;
            $display("FAIL init_clocks: got %0d rises (ready=%0b) expected %0d", rises, seen, INITC);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL init_cs_mosi: got %0d cycles with CS low or mosi low expected 0", bad);
        end
        n_checks++;
        if (bad_per !== 0) begin
            n_fail++;
            $display("FAIL init_period: got %0d bad periods expected 0", bad_per);
        end
    endtask

    task automatic test_cmd0;
        obs_t o;
        xfer(6'd0, 32'h0, 1'b0, 1'b0, 16, 40'h01_0000_0000, o);
        n_checks++;
        if (o.frame !== 48'h40_0000_0000_95) begin
            n_fail++; $display("FAIL cmd0_frame: got %h expected %h", o.frame, 48'h40_0000_0000_95);
        end
        n_checks++;
        if (o.n_sent !== 1 || o.n_rdy !== 1 || o.n_to !== 0 || !o.done) begin
            n_fail++; $display("FAIL cmd0_pulses: got sent=%0d rdy=%0d to=%0d done=%0b expected 1 1 0 1",
                               o.n_sent, o.n_rdy, o.n_to, o.done);
        end
        n_checks++;
        if (o.resp !== 40'h01_0000_0000 || o.to !== 1'b0) begin
            n_fail++; $display("FAIL cmd0_resp: got %h to=%b expected %h to=0", o.resp, o.to, 40'h01_0000_0000);
        end
    endtask

    task automatic test_cmd8;
        obs_t o;
        xfer(6'd8, 32'h1AA, 1'b1, 1'b0, int'($urandom_range(0, 20)), 40'h01_0000_01AA, o);
        n_checks++;
        if (o.frame !== 48'h48_0000_01AA_87) begin
            n_fail++; $display("FAIL cmd8_frame: got %h expected %h", o.frame, 48'h48_0000_01AA_87);
        end
        n_checks++;
        if (o.resp !== 40'h01_0000_01AA || o.n_rdy !== 1 || o.to !== 1'b0) begin
            n_fail++; $display("FAIL cmd8_resp: got %h rdy=%0d to=%b expected %h 1 0", o.resp, o.n_rdy, o.to, 40'h01_0000_01AA);
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        xfer(6'd0, 32'h0, 1'b0, 1'b0, RTO * 8, 40'h01_0000_0000, o);
        n_checks++;
        if (o.resp !== 40'hFF_FFFF_FFFF || o.to !== 1'b1 || o.n_to !== 1 || o.n_rdy !== 1) begin
            n_fail++; $display("FAIL timeout_resp: got %h to=%b nto=%0d rdy=%0d expected all ones 1 1 1",
                               o.resp, o.to, o.n_to, o.n_rdy);
        end
        n_checks++;
        if (o.trail !== TRAILC || !o.done) begin
            n_fail++; $display("FAIL timeout_trail: got %0d clocks done=%0b expected %0d", o.trail, o.done, TRAILC);
        end
        xfer(6'd8, 32'h1AA, 1'b0, 1'b0, RTO * 8 - 1, 40'h05_0000_0000, o);
        n_checks++;
        if (o.resp !== 40'h05_0000_0000 || o.n_to !== 0 || o.n_rdy !== 1) begin
            n_fail++; $display("FAIL last_poll_bit: got %h nto=%0d rdy=%0d expected %h 0 1",
                               o.resp, o.n_to, o.n_rdy, 40'h05_0000_0000);
        end
    endtask

    task automatic test_rates;
        obs_t o;
        xfer(6'd8, 32'h1AA, 1'b1, 1'b1, 3, 40'h01_0000_01AA, o);
        n_checks++;
        if (o.bad_period !== 0 || o.n_period < 80) begin
            n_fail++; $display("FAIL fast_period: got %0d bad of %0d expected 0 bad", o.bad_period, o.n_period);
        end
        xfer(6'd0, 32'h0, 1'b0, 1'b0, 3, 40'h01_0000_0000, o);
        n_checks++;
        if (o.bad_period !== 0 || o.n_period < 50) begin
            n_fail++; $display("FAIL slow_period: got %0d bad of %0d expected 0 bad", o.bad_period, o.n_period);
        end
    endtask

    task automatic test_back_to_back;
        obs_t        o;
        logic [5:0]  c;
        logic [31:0] a;
        logic        lng, fst;
        int          ones;
        logic [39:0] r;
        for (int k = 0; k < 8; k++) begin
            c = 6'($urandom); a = $urandom; lng = 1'($urandom); fst = 1'($urandom);
            ones = int'($urandom_range(0, RTO * 8 + 2));
            r = {1'b0, 7'($urandom), $urandom};
            xfer(c, a, lng, fst, ones, r, o);
            n_checks++;
            if (o.frame !== ref_frame(c, a) || o.n_sent !== 1) begin
                n_fail++; $display("FAIL rand_frame[%0d]: got %h sent=%0d expected %h sent=1", k, o.frame, o.n_sent, ref_frame(c, a));
            end
            n_checks++;
            if (o.resp !== ref_resp(lng, ones, r) || o.n_rdy !== 1 || o.to !== (ones >= RTO * 8)) begin
                n_fail++; $display("FAIL rand_resp[%0d]: got %h rdy=%0d to=%b expected %h 1 %b",
                                   k, o.resp, o.n_rdy, o.to, ref_resp(lng, ones, r), ones >= RTO * 8);
            end
            n_checks++;
            if (o.bad_period !== 0 || o.trail !== TRAILC || !o.done) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got badper=%0d trail=%0d done=%0b expected 0 %0d 1",
                                   k, o.bad_period, o.trail, o.done, TRAILC);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit   ok;
        logic prev_sck;
        int   nbits, rises, pulses, cs_low;
        bit   seen;
        wait_ready(ok);
        cmd_valid = 1'b1; command = 6'd8; arg = 32'h1AA; resp_long = 1'b1; fast_clk = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        prev_sck = sdclk; nbits = 0;
        for (int i = 0; i < 2000 && nbits < 20; i++) begin
            @(negedge clk);
            if (sdclk && !prev_sck && !sd_chip_select) nbits++;
            prev_sck = sdclk;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (!ok || nbits !== 20 || sd_chip_select !== 1'b1 || cmd_ready !== 1'b0 || mosi !== 1'b1) begin
            n_fail++; $display("FAIL midreset_state: got bits=%0d cs=%b rdy=%b mosi=%b expected 20 1 0 1",
                               nbits, sd_chip_select, cmd_ready, mosi);
        end
        prev_sck = sdclk; rises = 0; pulses = 0; cs_low = 0; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (command_sent || response_ready) pulses++;
            if (!sd_chip_select) cs_low++;
            if (sdclk && !prev_sck) rises++;
            if (cmd_ready) begin
                seen = 1'b1;
                break;
            end
            prev_sck = sdclk;
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 0 || cs_low !== 0) begin
            n_fail++; $display("FAIL midreset_quiet: got %0d pulses %0d cs-low cycles expected 0 0", pulses, cs_low);
        end
        n_checks++;
        if (!seen || rises !== INITC) begin
            n_fail++; $display("FAIL midreset_init: got %0d rises ready=%0b expected %0d", rises, seen, INITC);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_timeout();
        test_rates();
        test_back_to_back();
        test_reset_mid_frame();
        test_cmd0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_spi_cmd_engine.md
Name: sd_spi_cmd_engine

Overview:
Parametrised SD-card SPI-mode command engine, successor to the fixed-rate sd_test controller. Runs the power-up clock sequence, then accepts commands over a valid/ready handshake. Each command is serialised as a 48-bit frame with CRC7, the engine polls for the response, and captures either an R1 (8-bit) or an R3/R7 (40-bit) response. Adds selectable slow/fast SPI clock, per-command response length, a response timeout and a trailing clock gap. It sits between the frame/sector reader and the SD card pins.

Parameters:
LOWFREQ_POWER2, 7, sdclk period = 2^LOWFREQ_POWER2 clk cycles in slow mode (must be >=1)
HIGHFREQ_POWER2, 1, sdclk period = 2^HIGHFREQ_POWER2 clk cycles in fast mode (must be >=1)
INIT_CLOCKS, 80, sdclk cycles issued with CS high after reset
RESP_TIMEOUT, 16, maximum poll bytes to wait for a response start bit
TRAIL_CLOCKS, 8, sdclk cycles issued with CS high after each response

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
command  in  6  command index; sampled when cmd_valid && cmd_ready
arg  in  32  command argument; sampled on accept
resp_long  in  1  1 = 40-bit response, 0 = R1 only; sampled on accept
fast_clk  in  1  1 = HIGHFREQ rate; sampled on accept (init always slow)
command_sent  out  1  one-clk pulse after frame bit 47 completes
response  out  40  captured response, R1 in [39:32]; held until the next accept
response_ready  out  1  one-clk pulse when response is valid (also on timeout)
timeout  out  1  one-clk pulse coincident with response_ready on timeout
miso  in  1  card data out
mosi  out  1  card data in
sdclk  out  1  SPI clock, mode 0, idles low
sd_chip_select  out  1  active-low card select

Behaviour:
- Reset values: cmd_ready=0, command_sent=0, response=0, response_ready=0, timeout=0, mosi=1, sdclk=0, sd_chip_select=1. State=INIT.
- Reset applies on any clk edge, including mid-frame or mid-poll. Next cycle CS=1 and INIT restarts the clock count.
- Bit timing: a divider counter generates sdclk. mosi updates on the sdclk falling edge, or at frame start while sdclk is low. miso is sampled on the clk cycle producing the sdclk rising edge.
- INIT: CS=1, mosi=1, INIT_CLOCKS slow sdclk cycles, then IDLE.
- IDLE: cmd_ready=1, sdclk low. On cmd_valid&&cmd_ready, latch inputs, CS=0 and go to SEND. cmd_valid is ignored in all other states.
- SEND: 48 bits MSB first: 0b01, command[5:0], arg[31:0], crc7[6:0], 1. After bit 47 the command_sent pulse fires and the engine goes to POLL.
- POLL: mosi=1. Each sampled 1 is discarded. The first sampled 0 is response bit 39, and the engine goes to RECV. If RESP_TIMEOUT*8 bits pass without a 0, then response=40'hFF_FFFF_FFFF, response_ready and timeout pulse, and the engine goes to TRAIL.
- RECV: mosi=1. Shift in the remaining 7 bits (short) or 39 bits (long). Short: response[31:0]=0. At the final bit, response is updated and response_ready pulses on the same clk.
- TRAIL: CS=1, mosi=1, TRAIL_CLOCKS sdclk cycles at the command's rate, then IDLE. cmd_ready rises the clk after TRAIL completes.
- Each frame uses exactly one rate; fast_clk changes mid-frame have no effect.
- Counter widths are sized with $clog2 of the parameters; no wrap is allowed within a phase.

Optional Feature:
SD_CRC_EN:
- Defined: crc7 is computed serially over frame bits 47..8 (poly x^7+x^3+1, init 0).
- Undefined: crc7 is a constant: 7'h4A for command 0, 7'h43 for command 8, 7'h7F otherwise (valid for CMD0 and CMD8 with arg 32'h1AA only).

Test Plan:
- LOWFREQ_POWER2=2, CMD0, arg=0, resp_long=0, miso drives 8'h01 after 2 idle poll bytes -> mosi frame 48'h40_0000_0000_95; command_sent pulses once; response=40'h01_0000_0000; single response_ready pulse; timeout=0.
- CMD8, arg=32'h1AA, resp_long=1, miso returns 40'h01_0000_01AA -> frame 48'h48_0000_01AA_87; response=40'h01_0000_01AA.
- RESP_TIMEOUT=4, miso held 1 -> after 32 poll bits, response=40'hFF_FFFF_FFFF with timeout and response_ready pulses on the same clk; CS high for 8 sdclk cycles, then cmd_ready=1.
- After reset -> exactly INIT_CLOCKS sdclk rising edges with CS=1 before cmd_ready rises; cmd_valid asserted during INIT is ignored.
- fast_clk=1, HIGHFREQ_POWER2=1 -> sdclk period is 2 clk cycles for the entire frame; a second command with fast_clk=0 -> period 4.
- rst pulsed for 1 clk during arg bit 20 -> next clk CS=1, cmd_ready=0, no command_sent or response_ready; INIT clocks rerun.
